// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type encodings and bus payload layouts for the memory stage.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD = 74;
  localparam int unsigned MS_TO_WS_BUS_WD = 70;
  localparam int unsigned MS_FWD_BUS_WD   = 40;

  typedef enum logic [2:0] {
    MEM_W  = 3'b000,
    MEM_B  = 3'b001,
    MEM_H  = 3'b010,
    MEM_BU = 3'b101,
    MEM_HU = 3'b110
  } mem_type_e;

  typedef struct packed {
    mem_type_e   mem_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

  typedef struct packed {
    logic        fwd_valid;
    logic        fwd_load_pending;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_fwd_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword/word out of load data and sign- or zero-extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  mem_type_e   mem_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  always_comb begin
    ld_byte = rdata[7:0];
    case (addr_lo)
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      2'd3:    ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    // a[0] deliberately ignored for halfwords: misalignment is not trapped here
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sext    = (mem_type == MEM_B) || (mem_type == MEM_H);
    case (mem_type)
      MEM_B, MEM_BU: data = {{24{sext & ld_byte[7]}}, ld_byte};
      MEM_H, MEM_HU: data = {{16{sext & ld_half[15]}}, ld_half};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches execute results, waits for load data, aligns it and hands off to writeback.
// Optional decode forwarding is enabled with `define MS_FWD_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_fwd
);

  logic          ms_valid;
  logic          buf_valid;
  logic [31:0]   rdata_buf;
  es_to_ms_bus_t bus_r;

  logic          ms_ready_go;
  logic [31:0]   load_raw;
  logic [31:0]   load_data;
  logic [31:0]   final_result;
  ms_to_ws_bus_t ws_bus;

  assign ms_ready_go    = !bus_r.res_from_mem || buf_valid || data_sram_data_ok;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Pipeline register and handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      bus_r    <= es_to_ms_bus_t'(ES_TO_MS_BUS_WD'(0));
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        bus_r <= es_to_ms_bus_t'(es_to_ms_bus);
      end
    end
  end

  // Holds load data that arrives while writeback is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      rdata_buf <= 32'h0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      buf_valid <= 1'b0;
    end else if (ms_valid && bus_r.res_from_mem && !buf_valid && data_sram_data_ok) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  assign load_raw = buf_valid ? rdata_buf : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .mem_type (bus_r.mem_type),
    .addr_lo  (bus_r.alu_result[1:0]),
    .rdata    (load_raw),
    .data     (load_data)
  );

  assign final_result = bus_r.res_from_mem ? load_data : bus_r.alu_result;

  always_comb begin
    ws_bus              = '0;
    ws_bus.gr_we        = bus_r.gr_we;
    ws_bus.dest         = bus_r.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = bus_r.pc;
  end

  assign ms_to_ws_bus = ws_bus;

`ifdef MS_FWD_EN
  ms_fwd_bus_t fwd;

  always_comb begin
    fwd                  = '0;
    fwd.fwd_valid        = ms_valid;
    fwd.fwd_load_pending = ms_valid && bus_r.res_from_mem && !ms_ready_go;
    fwd.gr_we            = bus_r.gr_we;
    fwd.dest             = bus_r.dest;
    fwd.result           = final_result;
  end

  assign ms_to_ds_fwd = fwd;
`else
  assign ms_to_ds_fwd = MS_FWD_BUS_WD'(0);
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, load alignment, stalls, buffering, reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [39:0] ms_to_ds_fwd;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_fwd      (ms_to_ds_fwd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_es(input logic v, input logic [2:0] mt, input logic rfm, input logic [31:0] alu);
    es_to_ms_valid = v;
    es_to_ms_bus   = {mt, rfm, 1'b1, 5'd3, alu, 32'h1c00_0100};
  endtask

  task automatic test_reset();
    resetn = 1'b0; ws_allowin = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    set_es(1'b0, 3'b000, 1'b0, 32'h0);
    #12;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ms_to_ws_valid); end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin got %b want 1", ms_allowin); end
    n_cmp++; if (ms_to_ds_fwd !== 40'h0) begin n_err++; $display("FAIL reset_fwd got %h want 0", ms_to_ds_fwd); end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    set_es(1'b1, 3'b000, 1'b0, 32'h1234_5678);
    step();
    set_es(1'b1, 3'b000, 1'b0, 32'hAAAA_0001);
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid got %b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus !== {1'b1, 5'd3, 32'h1234_5678, 32'h1c00_0100}) begin
      n_err++; $display("FAIL pass_bus got %h want %h", ms_to_ws_bus, {1'b1, 5'd3, 32'h1234_5678, 32'h1c00_0100});
    end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL pass_allowin got %b want 1", ms_allowin); end
    step();
    set_es(1'b0, 3'b000, 1'b0, 32'h0);
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hAAAA_0001) begin n_err++; $display("FAIL b2b_result got %h want AAAA0001", ms_to_ws_bus[63:32]); end
    step();
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL pass_drain got %b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_load(input string name, input logic [2:0] mt, input logic [1:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
    set_es(1'b1, mt, 1'b1, {30'h0400_0000, a});
    step();
    set_es(1'b0, 3'b000, 1'b0, 32'h0);
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL %s_wait got %b want 0", name, ms_to_ws_valid); end
    data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid got %b want 1", name, ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus[63:32] !== exp) begin n_err++; $display("FAIL %s_result got %h want %h", name, ms_to_ws_bus[63:32], exp); end
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
  endtask

  task automatic test_delayed();
    set_es(1'b1, 3'b000, 1'b1, 32'h0000_0040);
    step();
    set_es(1'b0, 3'b000, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL delay_valid[%0d] got %b want 0", i, ms_to_ws_valid); end
      n_cmp++; if (ms_allowin !== 1'b0) begin n_err++; $display("FAIL delay_allowin[%0d] got %b want 0", i, ms_allowin); end
`ifdef MS_FWD_EN
      n_cmp++; if (ms_to_ds_fwd[39:38] !== 2'b11) begin n_err++; $display("FAIL delay_fwd_pending[%0d] got %b want 11", i, ms_to_ds_fwd[39:38]); end
`endif
      step();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344;
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL delay_release got %b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h1122_3344) begin n_err++; $display("FAIL delay_result got %h want 11223344", ms_to_ws_bus[63:32]); end
`ifdef MS_FWD_EN
    n_cmp++; if (ms_to_ds_fwd !== {2'b10, 1'b1, 5'd3, 32'h1122_3344}) begin n_err++; $display("FAIL delay_fwd got %h", ms_to_ds_fwd); end
`endif
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_wb_stall();
    ws_allowin = 1'b0;
    set_es(1'b1, 3'b000, 1'b1, 32'h0000_0080);
    step();
    set_es(1'b0, 3'b000, 1'b0, 32'h0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #2;
    n_cmp++; if (ms_allowin !== 1'b0) begin n_err++; $display("FAIL stall_allowin got %b want 0", ms_allowin); end
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0BAD_F00D;
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL buf_valid_out got %b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL buf_hold got %h want DEADBEEF", ms_to_ws_bus[63:32]); end
    step();
    ws_allowin = 1'b1;
    #2;
    n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL buf_release_allowin got %b want 1", ms_allowin); end
    n_cmp++; if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL buf_release got %h want DEADBEEF", ms_to_ws_bus[63:32]); end
    step();
    // next load must wait again, proving the buffer cleared
    set_es(1'b1, 3'b101, 1'b1, 32'h0000_0000);
    step();
    set_es(1'b0, 3'b000, 1'b0, 32'h0);
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL buf_cleared got %b want 0", ms_to_ws_valid); end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FF55;
    #2;
    n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h0000_0055) begin n_err++; $display("FAIL buf_next_result got %h want 00000055", ms_to_ws_bus[63:32]); end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    set_es(1'b1, 3'b000, 1'b1, 32'h0000_0100);
    step();
    set_es(1'b0, 3'b000, 1'b0, 32'h0);
    #2;
    n_cmp++; if (ms_allowin !== 1'b0) begin n_err++; $display("FAIL midrst_pre_allowin got %b want 0", ms_allowin); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL midrst_allowin got %b want 1", ms_allowin); end
    @(negedge clk);
    resetn = 1'b1;
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777;
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stray_valid got %b want 0", ms_to_ws_valid); end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL midrst_stray_allowin got %b want 1", ms_allowin); end
    step();
    data_sram_data_ok = 1'b0;
    #2;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL midrst_after got %b want 0", ms_to_ws_valid); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load("ld_b",  3'b001, 2'b11, 32'h80AB_CDEF, 32'hFFFF_FF80);
    test_load("ld_bu", 3'b101, 2'b11, 32'h80AB_CDEF, 32'h0000_0080);
    test_load("ld_b1", 3'b001, 2'b01, 32'h80AB_CD7F, 32'hFFFF_FFCD);
    test_load("ld_h",  3'b010, 2'b10, 32'h8001_1234, 32'hFFFF_8001);
    test_load("ld_hu", 3'b110, 2'b00, 32'h8001_1234, 32'h0000_1234);
    test_load("ld_h3", 3'b010, 2'b11, 32'h8001_F234, 32'hFFFF_8001);
    test_load("ld_w",  3'b000, 2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D);
    test_delayed();
    test_wb_stall();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
